// File: rtl/block_average_downscaler_if.sv
// Source-read / frame-buffer-write bundle shared by the zoom engines.
// The engine drives the master side; memories and control sit on the slave side.
interface block_average_downscaler_if;
    logic        enable;
    logic [2:0]  zoom_level;
    logic [7:0]  pixel_in;
    logic [14:0] read_addr;
    logic [7:0]  pixel_out;
    logic [18:0] write_addr;
    logic        write_en;
    logic        done;

    modport master (
        input  enable, zoom_level, pixel_in,
        output read_addr, pixel_out, write_addr, write_en, done
    );

    modport slave (
        output enable, zoom_level, pixel_in,
        input  read_addr, pixel_out, write_addr, write_en, done
    );
endinterface

// File: rtl/block_average_downscaler.sv
// NxN block-average zoom-out engine (1x/2x/4x) for a 160x120 8-bit source.
// Define BLOCK_AVG_ROUND_EN for round-half-up averaging instead of truncation.
module block_average_downscaler #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120
) (
    input  logic                       clk,
    input  logic                       reset,
    block_average_downscaler_if.master bus
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t      r_state;
    logic [1:0]  r_nlog;
    logic [1:0]  r_dx;
    logic [1:0]  r_dy;
    logic [7:0]  r_xo;
    logic [6:0]  r_yo;
    logic [14:0] r_ptr;
    logic [11:0] r_acc;
    logic [7:0]  r_pix;
    logic        r_we;
    logic        r_done;

    logic [1:0]  w_zoom_nlog;
    logic [1:0]  w_nm1;
    logic [7:0]  w_wm1;
    logic [14:0] w_last;
    logic [11:0] w_rnd;
    logic [11:0] w_sum;
    logic [7:0]  w_avg;
    logic [6:0]  w_sy;
    logic [7:0]  w_sx;
    logic [14:0] w_raddr;

    always_comb begin
        w_zoom_nlog = 2'd0;
        w_nm1       = 2'd0;
        unique case (1'b1)
            (bus.zoom_level == 3'd0): w_zoom_nlog = 2'd2;
            (bus.zoom_level == 3'd1): w_zoom_nlog = 2'd1;
            default:                  w_zoom_nlog = 2'd0;
        endcase
        unique case (1'b1)
            (r_nlog == 2'd2): w_nm1 = 2'd3;
            (r_nlog == 2'd1): w_nm1 = 2'd1;
            default:          w_nm1 = 2'd0;
        endcase
    end

    assign w_wm1  = 8'((IMG_WIDTH_IN >> r_nlog) - 1);
    assign w_last = 15'((IMG_WIDTH_IN >> r_nlog) *
                        (IMG_HEIGHT_IN >> r_nlog) - 1);

`ifdef BLOCK_AVG_ROUND_EN
    assign w_rnd = 12'((32'd1 << {r_nlog, 1'b0}) >> 1);
`else
    assign w_rnd = 12'd0;
`endif

    // pixel_in lags read_addr by one cycle, so DRAIN folds in the last sample
    assign w_sum = r_acc + {4'd0, bus.pixel_in};
    assign w_avg = 8'((w_sum + w_rnd) >> {r_nlog, 1'b0});

    assign w_sy    = (r_yo << r_nlog) + {5'd0, r_dy};
    assign w_sx    = (r_xo << r_nlog) + {6'd0, r_dx};
    assign w_raddr = 15'(w_sy) * 15'(IMG_WIDTH_IN) + 15'(w_sx);

    assign bus.read_addr  = (r_state == READ) ? w_raddr : 15'd0;
    assign bus.write_addr = {4'd0, r_ptr};
    assign bus.pixel_out  = r_pix;
    assign bus.write_en   = r_we;
    assign bus.done       = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_nlog  <= 2'd0;
            r_dx    <= 2'd0;
            r_dy    <= 2'd0;
            r_xo    <= 8'd0;
            r_yo    <= 7'd0;
            r_ptr   <= 15'd0;
            r_acc   <= 12'd0;
            r_pix   <= 8'd0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
        end else if (!bus.enable) begin
            r_state <= IDLE;
            r_dx    <= 2'd0;
            r_dy    <= 2'd0;
            r_xo    <= 8'd0;
            r_yo    <= 7'd0;
            r_ptr   <= 15'd0;
            r_acc   <= 12'd0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_nlog  <= w_zoom_nlog;
                    r_dx    <= 2'd0;
                    r_dy    <= 2'd0;
                    r_xo    <= 8'd0;
                    r_yo    <= 7'd0;
                    r_ptr   <= 15'd0;
                    r_acc   <= 12'd0;
                    r_state <= READ;
                end
                READ: begin
                    if (r_dx != 2'd0 || r_dy != 2'd0)
                        r_acc <= w_sum;
                    if (r_dx == w_nm1) begin
                        r_dx <= 2'd0;
                        if (r_dy == w_nm1) begin
                            r_dy    <= 2'd0;
                            r_state <= DRAIN;
                        end else begin
                            r_dy <= r_dy + 2'd1;
                        end
                    end else begin
                        r_dx <= r_dx + 2'd1;
                    end
                end
                DRAIN: begin
                    r_pix   <= w_avg;
                    r_we    <= 1'b1;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_ptr <= r_ptr + 15'd1;
                    r_acc <= 12'd0;
                    if (r_xo == w_wm1) begin
                        r_xo <= 8'd0;
                        r_yo <= r_yo + 7'd1;
                    end else begin
                        r_xo <= r_xo + 8'd1;
                    end
                    if (r_ptr == w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= READ;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_average_downscaler.sv
// Directed bench for block_average_downscaler: vector table plus
// hand-written reset, arithmetic, address-order and abort sequences.
module tb_block_average_downscaler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    block_average_downscaler_if bus();

    block_average_downscaler #(
        .IMG_WIDTH_IN (160),
        .IMG_HEIGHT_IN(120)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] src [0:19199];

    always @(posedge clk) bus.pixel_in <= src[bus.read_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_idx   = 0;
    int   last_wa  = -1;
    int   mon_zoom = 0;
    int   t0       = 0;
    logic prev_we  = 1'b0;

    typedef struct {
        int zoom;
        int fill;
        int stop;
        int exp_writes;
        int exp_last;
        int exp_cycles;
        int exp_done;
    } vec_t;

    vec_t vecs [7];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int blk_n(input int z);
        if (z == 0) return 4;
        if (z == 1) return 2;
        return 1;
    endfunction

    function automatic int model_pix(input int z, input int p);
        int n;
        int w;
        int xo;
        int yo;
        int s;
        n = blk_n(z);
        w = 160 / n;
        xo = p % w;
        yo = p / w;
        s = 0;
        for (int dy = 0; dy < n; dy++)
            for (int dx = 0; dx < n; dx++)
                s += int'(src[(yo * n + dy) * 160 + xo * n + dx]);
`ifdef BLOCK_AVG_ROUND_EN
        return (s + n * n / 2) / (n * n);
`else
        return s / (n * n);
`endif
    endfunction

    always @(negedge clk) begin
        if (bus.write_en) begin
            if (prev_we) chk("write_pulse_width", 32'd2, 32'd1);
            chk("write_addr", 32'(bus.write_addr), wr_idx);
            chk("pixel_out", 32'(bus.pixel_out),
                model_pix(mon_zoom, wr_idx));
            last_wa = int'(bus.write_addr);
            wr_idx++;
        end
        prev_we = bus.write_en;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_src(input int f);
        for (int a = 0; a < 19200; a++) begin
            if (f == 1) src[a] = 8'd255;
            else if (f == 2) src[a] = 8'd0;
            else src[a] = 8'((a * 37 + (a / 160) * 11 + 5) & 255);
        end
    endtask

    task automatic start_frame(input int z);
        bus.zoom_level = 3'(z);
        mon_zoom = z;
        wr_idx = 0;
        last_wa = -1;
        bus.enable = 1'b1;
        step();
        t0 = cyc;
        chk("first_read_addr", 32'(bus.read_addr), 32'd0);
    endtask

    task automatic stop_frame();
        bus.enable = 1'b0;
        step();
        chk("idle_write_en", 32'(bus.write_en), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
    endtask

    int   k;
    int   exp_avg;
    int   ao [16];
    int   held;

    initial begin
        vecs[0] = '{0, 1, 0,   1200, 1199, 21600, 1};
        vecs[1] = '{2, 0, 300, 300,  299,  899,   0};
        vecs[2] = '{6, 0, 300, 300,  299,  899,   0};
        vecs[3] = '{3, 0, 200, 200,  199,  599,   0};
        vecs[4] = '{7, 0, 200, 200,  199,  599,   0};
        vecs[5] = '{0, 0, 60,  60,   59,   1079,  0};
        vecs[6] = '{1, 0, 120, 120,  119,  719,   0};
        ao = '{0, 1, 2, 3, 160, 161, 162, 163,
               320, 321, 322, 323, 480, 481, 482, 483};

        reset = 1'b1;
        bus.enable = 1'b0;
        bus.zoom_level = 3'd0;
        fill_src(0);
        repeat (3) step();
        chk("rst_read_addr", 32'(bus.read_addr), 32'd0);
        chk("rst_pixel_out", 32'(bus.pixel_out), 32'd0);
        chk("rst_write_addr", 32'(bus.write_addr), 32'd0);
        chk("rst_write_en", 32'(bus.write_en), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        step();

        // reset mid-frame with enable still high
        start_frame(1);
        k = 0;
        while (wr_idx < 3 && k < 100) begin step(); k++; end
        chk("reset_seq_writes", wr_idx, 3);
        reset = 1'b1;
        step();
        chk("midrst_read_addr", 32'(bus.read_addr), 32'd0);
        chk("midrst_pixel_out", 32'(bus.pixel_out), 32'd0);
        chk("midrst_write_addr", 32'(bus.write_addr), 32'd0);
        chk("midrst_write_en", 32'(bus.write_en), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        held = 0;
        repeat (8) begin
            step();
            if (bus.write_en) held++;
        end
        chk("rst_held_write_en", held, 0);
        reset = 1'b0;
        bus.enable = 1'b0;
        step();

        // 2x arithmetic on a single hand-built block
        fill_src(2);
        src[0] = 8'd10;
        src[1] = 8'd20;
        src[160] = 8'd30;
        src[161] = 8'd42;
`ifdef BLOCK_AVG_ROUND_EN
        exp_avg = 26;
`else
        exp_avg = 25;
`endif
        start_frame(1);
        k = 0;
        while (!bus.write_en && k < 20) begin step(); k++; end
        chk("arith_write_seen", 32'(bus.write_en), 32'd1);
        chk("arith_write_addr", 32'(bus.write_addr), 32'd0);
        chk("arith_pixel_out", 32'(bus.pixel_out), exp_avg);
        stop_frame();

        // 4x read-address order for the first block
        fill_src(0);
        start_frame(0);
        for (int i = 0; i < 16; i++) begin
            chk("addr_order", 32'(bus.read_addr), ao[i]);
            step();
        end
        chk("addr_drain_zero", 32'(bus.read_addr), 32'd0);
        step();
        chk("addr_write_en", 32'(bus.write_en), 32'd1);
        step();
        chk("addr_block2", 32'(bus.read_addr), 32'd4);
        stop_frame();

        // vector table: full and partial frames
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            fill_src(v.fill);
            start_frame(v.zoom);
            bus.zoom_level = (v.zoom == 0) ? 3'd2 : 3'd0;
            k = 0;
            while (!bus.done && (v.stop == 0 || wr_idx < v.stop)
                   && k < 60000) begin
                step();
                k++;
            end
            chk("vec_timeout", (k < 60000) ? 32'd0 : 32'd1, 32'd0);
            chk("vec_writes", wr_idx, v.exp_writes);
            chk("vec_last_addr", last_wa, v.exp_last);
            chk("vec_cycles", cyc - t0, v.exp_cycles);
            chk("vec_done", 32'(bus.done), v.exp_done);
            if (v.exp_done != 0) begin
                repeat (5) step();
                chk("done_held", 32'(bus.done), 32'd1);
                chk("no_writes_after_done", wr_idx, v.exp_writes);
            end
            stop_frame();
        end

        // abort after 100 writes, then restart and finish a 2x frame
        fill_src(0);
        start_frame(1);
        k = 0;
        while (wr_idx < 100 && k < 2000) begin step(); k++; end
        chk("abort_writes", wr_idx, 100);
        bus.enable = 1'b0;
        step();
        chk("abort_write_en", 32'(bus.write_en), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_read_addr", 32'(bus.read_addr), 32'd0);
        chk("abort_pixel_hold", 32'(bus.pixel_out), model_pix(1, 99));
        step();
        chk("abort_write_en2", 32'(bus.write_en), 32'd0);
        start_frame(1);
        k = 0;
        while (!bus.done && k < 40000) begin step(); k++; end
        chk("restart_done", 32'(bus.done), 32'd1);
        chk("restart_writes", wr_idx, 4800);
        chk("restart_last_addr", last_wa, 4799);
        chk("restart_cycles", cyc - t0, 28800);
        stop_frame();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_average_downscaler.md
# block_average_downscaler

Zoom-out engine for the 160x120, 8-bit grayscale source image. It reduces the image by 1x, 2x or 4x using N×N block averaging, and writes the result sequentially into the output frame buffer. It uses the same source-memory read interface and frame-buffer write interface as the zoom-in path, so the display controller can select either engine.

## Interface
- `IMG_WIDTH_IN`, 160, source image width in pixels
- `IMG_HEIGHT_IN`, 120, source image height in pixels
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  level; high runs or holds a frame, low aborts and returns to IDLE
- `zoom_level`  in  3  0 = 4x down (40x30), 1 = 2x down (80x60), 2 = 1x (160x120); values 3–7 behave as 2
- `pixel_in`  in  8  source data; valid one cycle after `read_addr` is presented (synchronous RAM)
- `read_addr`  out  15  source address, `y*IMG_WIDTH_IN + x`
- `pixel_out`  out  8  averaged pixel, registered
- `write_addr`  out  19  frame-buffer address, equal to the sequential write pointer
- `write_en`  out  1  one-cycle write strobe
- `done`  out  1  level; high once the frame is complete

## Operation
- **Zoom latch.** `zoom_level` is latched on the IDLE→READ transition. Changes to it mid-frame are ignored.
  - N = 4, 2 or 1.
  - k = 4, 2 or 0, where k = log2(N²).
  - Output size W×H = 40x30, 80x60 or 160x120.
- **States:** IDLE, READ, DRAIN, WRITE, DONE.
  - IDLE: when `enable` = 1, latch zoom, clear the block counters and accumulator, and go to READ.
  - READ: lasts N² cycles.
    - Present `read_addr` = (y_out·N+dy)·160 + x_out·N + dx.
    - dx is the inner loop and dy the outer loop, each running 0..N-1.
    - From the 2nd READ cycle onward, add `pixel_in` to the accumulator.
    - After the last (dx, dy) pair, go to DRAIN.
  - DRAIN: add the final `pixel_in`. Register `pixel_out` = (acc + pixel_in) >> k. Go to WRITE.
  - WRITE: `write_en` = 1, `write_addr` = ptr.
    - Then increment ptr, advance x_out (wrapping at W-1 and incrementing y_out), and clear the accumulator.
    - If ptr = W·H−1, go to DONE; otherwise go to READ.
  - DONE: `done` = 1. Hold until `enable` = 0, then go to IDLE. The engine does not auto-restart.
- **Accumulator:** 12 bits (maximum sum 16·255 = 4080). No saturation is needed.
- **Abort.** `enable` = 0 in any state means IDLE on the next edge.
  - `write_en` and `done` are 0 from that edge.
  - Counters, ptr and accumulator are cleared.
  - `pixel_out` holds its value.
- **Priority:** `reset` has priority over `enable`.

## Timing
- **Reset values:**
  - `read_addr` = 0
  - `pixel_out` = 0
  - `write_addr` = 0
  - `write_en` = 0
  - `done` = 0
  - State is IDLE.
- **Read address.** `read_addr` is combinational from the registered counters. It is 0 outside READ.
- **Cycles per output pixel:** N²+2.
  - READ: N² cycles.
  - DRAIN: 1 cycle.
  - WRITE: 1 cycle.
- **Frame latency.** From the first READ cycle to the last WRITE cycle: W·H·(N²+2) cycles.
  - 4x: 1200·18 = 21600 cycles.
  - 2x: 4800·6 = 28800 cycles.
  - 1x: 19200·3 = 57600 cycles.
- **Done.** `done` rises on the edge after the last WRITE cycle.
- **Write pulse.** `write_en` is high for exactly one cycle per output pixel, with `pixel_out` and `write_addr` stable in that same cycle.
- **Write-address range.** `write_addr` increments from 0 to W·H−1 with no gaps. It never wraps within a frame.

## Configuration
- `BLOCK_AVG_ROUND_EN`
  - Defined: `pixel_out` = (acc + (N²>>1)) >> k, i.e. round-half-up. No overflow is possible: the maximum is (4080+8)>>4 = 255.
  - Undefined: `pixel_out` = acc >> k, i.e. truncation.
  - In 1x mode both give `pixel_out` = source pixel.

## Test plan
- **Reset.** Assert `reset` with `enable` = 1 mid-frame → next cycle all outputs are 0 and state is IDLE; `write_en` stays 0 while `reset` is held.
- **2x arithmetic.** zoom 1, source (0,0)=10, (1,0)=20, (0,1)=30, (1,1)=42 (sum 102) → first write: `write_addr` 0, `pixel_out` 25. With `BLOCK_AVG_ROUND_EN`: 26.
- **4x address order.** zoom 0 → first-block `read_addr` sequence 0,1,2,3,160,161,162,163,320..323,480..483. Second block starts at 4.
- **4x full frame.** zoom 0, all source 255 → 1200 writes, all `pixel_out` 255, last `write_addr` 1199, `done` high exactly 21600 cycles after the first READ cycle, and it stays high.
- **1x passthrough.** zoom 2 (also repeat with zoom 6) → 19200 writes, each `pixel_out` equals the source at the same address, `write_addr` equals the `read_addr` of that pixel.
- **Abort and restart.** zoom 1, drop `enable` after 100 writes → `write_en` is 0 from the next edge. Re-raise `enable` → the frame restarts at `write_addr` 0 / `read_addr` 0 and completes with 4800 writes.
